// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N_BTN push-buttons with a single shared hold timer.
// A round-robin scheduler lends the timer to one button whose synchronized level
// differs from its committed level. The new level is committed only after it holds
// for DEBOUNCE_CYCLES. If it bounces back early, the window is dropped.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   button         raw asynchronous button levels
//   stable         debounced committed levels
//   press          one-cycle pulse on a committed 0->1
//   release_pulse  one-cycle pulse on a committed 1->0 ("release" is a reserved word)
//   busy           timer currently owned
//   owner          index of the timer owner, 0 when idle
module debounce_scheduler #(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned IDX_W           = 2,
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] stable,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic             busy,
  output logic [IDX_W-1:0] owner
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_BTN - 1);
  localparam logic [IDX_W:0]   NBtnExt = (IDX_W + 1)'(N_BTN);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StTiming} state_e;

  state_e             state_q, state_d;
  logic [N_BTN-1:0]   sync0_q, sync1_q;
  logic [N_BTN-1:0]   stable_q, stable_d;
  logic [N_BTN-1:0]   press_q, press_d;
  logic [N_BTN-1:0]   release_q, release_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               busy_q, busy_d;

  logic [N_BTN-1:0]   pending;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   ptr_after_owner;

  // A set bit means the synchronized level disagrees with the committed level.
  assign pending = sync1_q ^ stable_q;

  // Round-robin scan starting at rr_ptr. The extra index bit holds rr_ptr+off
  // before the wrap, so N_BTN does not have to be a power of two.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 0; off < N_BTN; off++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(off);
      if (cand >= NBtnExt) begin
        cand = cand - NBtnExt;
      end
      if (!grant_valid && pending[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // The pointer moves past the last owner on abort and on commit alike. This keeps
  // a bouncing button from holding the timer forever.
  assign ptr_after_owner = (owner_q == LastIdx) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;

    case (state_q)
      StIdle: begin
        owner_d = '0;
        if (grant_valid) begin
          owner_d = grant_idx;
          cnt_d   = '0;
          state_d = StTiming;
        end
      end
      StTiming: begin
        if (sync1_q[owner_q] == stable_q[owner_q]) begin
          // Input bounced back: drop the window and leave the level as it was.
          state_d  = StIdle;
          rr_ptr_d = ptr_after_owner;
          owner_d  = '0;
        end else if (cnt_q == CntLast) begin
          stable_d[owner_q] = sync1_q[owner_q];
          if (sync1_q[owner_q]) begin
            press_d[owner_q] = 1'b1;
          end else begin
            release_d[owner_q] = 1'b1;
          end
          rr_ptr_d = ptr_after_owner;
          owner_d  = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = '0;
      end
    endcase

    busy_d = (state_d == StTiming);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sync0_q   <= '0;
      sync1_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q     <= '0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync0_q   <= button;
      sync1_q   <= sync0_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
    end
  end

  assign stable        = stable_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler. A timestamp-based reference model predicts the
// outputs on every cycle. Directed scenarios add explicit edge-accurate checks.
module tb_debounce_scheduler;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 4;
  localparam int D  = 8;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  button;
  logic [N-1:0]  stable;
  logic [N-1:0]  press;
  logic [N-1:0]  release_pulse;
  logic          busy;
  logic [IW-1:0] owner;

  debounce_scheduler #(
    .N_BTN          (N),
    .IDX_W          (IW),
    .CNT_W          (CW),
    .DEBOUNCE_CYCLES(D)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button       (button),
    .stable       (stable),
    .press        (press),
    .release_pulse(release_pulse),
    .busy         (busy),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. hist holds the button values sampled at the last two edges,
  // so hist[0] is the value the block sees after its two-stage input delay.
  // A window opens at edge m_grant and commits exactly D edges later.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_stable, m_press, m_rel;
  int           m_owner, m_grant, m_edge, m_ptr;
  int           press_cnt[N];
  int           rel_cnt[N];

  task automatic model_reset();
    hist      = {};
    hist.push_back('0);
    hist.push_back('0);
    m_stable  = '0;
    m_press   = '0;
    m_rel     = '0;
    m_owner   = -1;
    m_grant   = 0;
    m_edge    = 0;
    m_ptr     = 0;
  endtask

  task automatic model_step(input logic [N-1:0] btn_now);
    logic [N-1:0] s;
    bit           found;
    s       = hist[0];
    m_press = '0;
    m_rel   = '0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && s[i] != m_stable[i]) begin
          found   = 1'b1;
          m_owner = i;
          m_grant = m_edge;
        end
      end
    end else if (s[m_owner] == m_stable[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (m_edge - m_grant == D) begin
      m_stable[m_owner] = s[m_owner];
      if (s[m_owner]) m_press[m_owner] = 1'b1;
      else            m_rel[m_owner]   = 1'b1;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
    hist.push_back(btn_now);
    void'(hist.pop_front());
    m_edge++;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  end

  // Monitor: advance the model on each edge, then compare just after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(button);
      #1;
      check("stable", 32'(stable), 32'(m_stable));
      check("press", 32'(press), 32'(m_press));
      check("release", 32'(release_pulse), 32'(m_rel));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("owner", 32'(owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      for (int i = 0; i < N; i++) begin
        if (press[i])         press_cnt[i]++;
        if (release_pulse[i]) rel_cnt[i]++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stable"}, 32'(stable), 32'd0);
    check({tag, "_press"}, 32'(press), 32'd0);
    check({tag, "_release"}, 32'(release_pulse), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_owner"}, 32'(owner), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int p0;
  int r0;

  initial begin
    rst_n  = 1'b0;
    button = '0;
    #1;
    check_all_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycles(5);

    // Clean press on button 1; the first edge after the drive is edge 0.
    @(negedge clk) button[1] = 1'b1;
    cycles(3);
    check("clean_busy_e2", 32'(busy), 32'd1);
    check("clean_owner_e2", 32'(owner), 32'd1);
    cycles(8);
    check("clean_stable_e10", 32'(stable[1]), 32'd1);
    check("clean_press_e10", 32'(press[1]), 32'd1);
    cycles(1);
    check("clean_press_e11", 32'(press[1]), 32'd0);
    // Clean release of button 1.
    @(negedge clk) button[1] = 1'b0;
    cycles(11);
    check("clean_rel_e10", 32'(release_pulse[1]), 32'd1);
    check("clean_stable_rel", 32'(stable[1]), 32'd0);
    cycles(5);

    // Bounce: 4 cycles high is too short to commit.
    p0 = press_cnt[2];
    @(negedge clk) button[2] = 1'b1;
    repeat (4) @(negedge clk);
    button[2] = 1'b0;
    cycles(20);
    check("bounce_no_press", 32'(press_cnt[2] - p0), 32'd0);
    check("bounce_stable", 32'(stable[2]), 32'd0);
    check("bounce_idle", 32'(busy), 32'd0);
    @(negedge clk) button[2] = 1'b1;
    repeat (20) @(negedge clk);
    check("hold_one_press", 32'(press_cnt[2] - p0), 32'd1);
    button = '0;
    cycles(40);

    // Contention with the round-robin pointer back at 0.
    do_reset();
    cycles(4);
    @(negedge clk) button = 4'b1001;
    cycles(11);
    check("cont_press0_e10", 32'(press), 32'b0001);
    cycles(1);
    check("cont_owner3_e11", 32'(owner), 32'd3);
    check("cont_busy_e11", 32'(busy), 32'd1);
    cycles(8);
    check("cont_press3_e19", 32'(press), 32'b1000);
    @(negedge clk) button = '0;
    cycles(40);

    // Fairness: button 0 keeps bouncing while button 1 is held.
    p0 = press_cnt[1];
    r0 = press_cnt[0];
    @(negedge clk) button[1] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (t % 3 == 0) button[0] = ~button[0];
    end
    check("fair_press1", 32'(press_cnt[1] - p0), 32'd1);
    check("fair_no_press0", 32'(press_cnt[0] - r0), 32'd0);
    @(negedge clk) button = '0;
    cycles(40);

    // Reset in mid-window: owner 2, counter at 5 after edge 7.
    @(negedge clk) button[2] = 1'b1;
    cycles(8);
    check("mid_owner2", 32'(owner), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = press_cnt[2];
    cycles(10);
    check("mid_no_early_press", 32'(press_cnt[2] - p0), 32'd0);
    cycles(1);
    check("mid_press2_e10", 32'(press[2]), 32'd1);
    @(negedge clk) button = '0;
    cycles(40);

    // Long idle.
    p0 = press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3];
    r0 = rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3];
    cycles(1000);
    check("idle_no_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] - p0),
          32'd0);
    check("idle_no_rel", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] - r0), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_owner", 32'(owner), 32'd0);

    // Random activity; the monitor compares every cycle.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) button[$urandom_range(0, N - 1)] ^= 1'b1;
    end
    @(negedge clk) button = '0;
    cycles(100);
    check("final_stable", 32'(stable), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_BTN push-buttons with one shared debounce timer instead of one counter per button.
- A round-robin scheduler gives the timer to one button at a time, namely a button whose synchronized input differs from its committed stable level.
- The block commits the new level only if the input holds for DEBOUNCE_CYCLES. It also emits one-cycle press/release pulses.
- Sits between the board button pins and the UI/control logic.

Parameters:
- N_BTN, 4, number of buttons (2..16).
- IDX_W, 2, width of the owner index; must equal ceil(log2(N_BTN)).
- CNT_W, 19, width of the shared timer.
- DEBOUNCE_CYCLES, 500000, stable-hold window in clk cycles; must satisfy 2 <= DEBOUNCE_CYCLES <= 2^CNT_W.

Ports:
- clk  input  1  system clock; all flops on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- button  input  N_BTN  raw asynchronous button levels.
- stable  output  N_BTN  debounced committed levels.
- press  output  N_BTN  one-cycle pulse when stable[i] goes 0->1.
- release  output  N_BTN  one-cycle pulse when stable[i] goes 1->0.
- busy  output  1  high while the timer is owned (TIMING state).
- owner  output  IDX_W  index of the current timer owner; 0 when idle.

Behaviour:
- Reset (async, rst_n=0):
  - sync0, sync1, stable, press, release, cnt, rr_ptr, owner = 0; busy = 0; state = IDLE.
  - Reset applied mid-TIMING aborts the window; no pulse is issued.
- Synchronizer:
  - Per bit, sync0 <= button and sync1 <= sync0. Only sync1 is used downstream.
  - pending[i] = sync1[i] ^ stable[i] (combinational).
- FSM states: IDLE, TIMING.
- IDLE:
  - If any pending bit is set, grant the first pending index found scanning rr_ptr, rr_ptr+1, ... with wrap at N_BTN (explicit compare; N_BTN need not be a power of 2).
  - On grant: owner <= index, cnt <= 0, state <= TIMING.
  - If nothing is pending, remain in IDLE with owner = 0.
- TIMING, evaluated each edge in priority order:
  1. Abort: sync1[owner] == stable[owner] (input bounced back). Then state <= IDLE, rr_ptr <= (owner+1) mod N_BTN, owner <= 0. stable is unchanged and no pulse is issued.
  2. Commit: cnt == DEBOUNCE_CYCLES-1. Then stable[owner] <= sync1[owner]; press[owner] or release[owner] <= 1 per direction; rr_ptr <= (owner+1) mod N_BTN; owner <= 0; state <= IDLE.
  3. Otherwise: cnt <= cnt+1.
- Non-owner input changes are ignored during TIMING. They remain pending, because pending is a level, and are served later; no event is lost.
- press and release are registered. They are high exactly one cycle, on the same edge that stable changes, and are 0 on every other cycle.
- busy = (state == TIMING), registered.
- Latency, uncontended: button changes before edge k.
  - sync1 updates at edge k+1; grant at edge k+2.
  - stable and pulse update at edge k+2+DEBOUNCE_CYCLES.
- Back-to-back service: after a commit or abort, the IDLE state consumes exactly one cycle before the next grant.
- Worst-case wait: (N_BTN-1) × (DEBOUNCE_CYCLES+1) cycles before a button is granted.
- Width rule: cnt is CNT_W bits and never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Fairness: the round-robin pointer advances past the last owner whether it aborted or committed, so no button can starve another.

Test Plan (DEBOUNCE_CYCLES=8, N_BTN=4):
- Clean press: button[1] 0->1 before edge 0, held.
  - Required: busy=1 and owner=1 from edge 2; stable[1]=1 and press[1]=1 at edge 10; press[1]=0 at edge 11.
  - Release the same way; release[1] must pulse at the matching edge.
- Bounce: button[2] goes high for 4 cycles, then low.
  - Required: abort and return to IDLE; stable[2]=0; no press pulse.
  - Then hold button[2] high for 20 cycles; required: a single press[2] pulse.
- Contention: button[0] and button[3] rise on the same cycle, rr_ptr=0.
  - Required: button[0] commits at edge 10; button[3] granted at edge 11 and commits at edge 19.
- Round-robin fairness: keep button[0] bouncing continuously while button[1] is held high.
  - Required: button[1] is granted after button[0]'s first abort, and press[1] occurs.
- Reset mid-window: assert rst_n=0 at cnt=5 while owning button[2].
  - Required: all outputs 0 immediately, asynchronously.
  - After release of reset with button[2] still high: a full new 8-cycle window, then press[2].
- Long idle: no button activity for 1000 cycles.
  - Required: busy=0, owner=0, no pulses.
